// File: rtl/exe_stage_mc_pkg.sv
// rtl/exe_stage_mc_pkg.sv - shared MIPS constants: ID decode, EXE commands, branch kinds, EX FSM states
package exe_stage_mc_pkg;

  // ID-stage primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_MUL  = 6'd13;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  // Execute-stage operation codes
  typedef enum logic [3:0] {
    CMD_ADD = 4'b0000,
    CMD_MUL = 4'b0001,
    CMD_SUB = 4'b0010,
    CMD_AND = 4'b0100,
    CMD_OR  = 4'b0101,
    CMD_NOR = 4'b0110,
    CMD_XOR = 4'b0111,
    CMD_SLL = 4'b1000,
    CMD_SRA = 4'b1001,
    CMD_SRL = 4'b1010
  } exe_cmd_e;

  // Branch kinds resolved in EX
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEZ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } br_type_e;

  // Multi-cycle execute controller
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Shift-add multiply runs one iteration per operand bit
  localparam logic [4:0] MUL_LAST_ITER = 5'd31;

  // EX/MEM pipeline register contents
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] st_val;
    logic [4:0]  dest;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
  } exmem_t;

  // Bubble: no writeback, no memory access, zero data
  localparam exmem_t EXMEM_BUBBLE = '0;

  // Branch target: word offset added to PC+4, wrapping modulo 2^32
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] offset);
    return pc + (offset << 2);
  endfunction

endpackage

// File: rtl/exe_stage_mc_if.sv
// rtl/exe_stage_mc_if.sv - ID/EX inputs, EX/MEM outputs and hazard/branch signals of the EX stage
interface exe_stage_mc_if;

  // ID/EX register side
  logic [3:0]  EXE_CMD;
  logic [31:0] Val1;
  logic [31:0] Val2;
  logic [31:0] Reg2;
  logic [31:0] PC_in;
  logic [1:0]  Br_type;
  logic [4:0]  Dest;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic        WB_EN;

  // EX/MEM register side
  logic [31:0] ALU_result;
  logic [31:0] ST_val;
  logic [4:0]  Dest_out;
  logic        MEM_R_EN_out;
  logic        MEM_W_EN_out;
  logic        WB_EN_out;

  // Pipeline control back to fetch/decode
  logic        freeze;
  logic        Br_taken;
  logic [31:0] Br_addr;

  // Upstream pipeline: drives the ID/EX values, consumes the results
  modport master (
    output EXE_CMD, Val1, Val2, Reg2, PC_in, Br_type, Dest, MEM_R_EN, MEM_W_EN, WB_EN,
    input  ALU_result, ST_val, Dest_out, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out,
    input  freeze, Br_taken, Br_addr
  );

  // Execute stage
  modport slave (
    input  EXE_CMD, Val1, Val2, Reg2, PC_in, Br_type, Dest, MEM_R_EN, MEM_W_EN, WB_EN,
    output ALU_result, ST_val, Dest_out, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out,
    output freeze, Br_taken, Br_addr
  );

endinterface

// File: rtl/exe_stage_mc_alu.sv
// rtl/exe_stage_mc_alu.sv - single-cycle combinational ALU for all non-multiply commands
module alu
  import exe_stage_mc_pkg::*;
(
  input  logic [3:0]  EXE_CMD,
  input  logic [31:0] Val1,
  input  logic [31:0] Val2,
  output logic [31:0] result
);

  logic [4:0] shamt;

  assign shamt = Val2[4:0];

  // Single-cycle result; MUL is produced by the iterative datapath, so it yields 0 here
  always_comb begin
    result = 32'd0;
    case (EXE_CMD)
      CMD_ADD: result = Val1 + Val2;
      CMD_SUB: result = Val1 - Val2;
      CMD_AND: result = Val1 & Val2;
      CMD_OR:  result = Val1 | Val2;
      CMD_NOR: result = ~(Val1 | Val2);
      CMD_XOR: result = Val1 ^ Val2;
      CMD_SLL: result = Val1 << shamt;
      CMD_SRA: result = $signed(Val1) >>> shamt;
      CMD_SRL: result = Val1 >> shamt;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/exe_stage_mc.sv
// rtl/exe_stage_mc.sv - execute stage with 1-cycle ALU, 32-cycle shift-add multiply and branch resolve
module exe_stage_mc
  import exe_stage_mc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  exe_stage_mc_if.slave bus
);

  state_e      state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [4:0]  cnt;
  exmem_t      exmem_q;

  logic [31:0] alu_res;
  logic        is_mul;
  logic        br_cond;
  logic        freeze_c;
  logic        taken_c;
  exmem_t      pass_through;

  alu u_alu (
    .EXE_CMD (bus.EXE_CMD),
    .Val1    (bus.Val1),
    .Val2    (bus.Val2),
    .result  (alu_res)
  );

  assign is_mul = (bus.EXE_CMD == CMD_MUL);

  // Entry formed from the current ID/EX values and the single-cycle ALU result
  always_comb begin
    pass_through            = EXMEM_BUBBLE;
    pass_through.alu_result = alu_res;
    pass_through.st_val     = bus.Reg2;
    pass_through.dest       = bus.Dest;
    pass_through.mem_r_en   = bus.MEM_R_EN;
    pass_through.mem_w_en   = bus.MEM_W_EN;
    pass_through.wb_en      = bus.WB_EN;
  end

  // Branch condition from the branch kind and operands
  always_comb begin
    br_cond = 1'b0;
    case (bus.Br_type)
      BR_BEZ:  br_cond = (bus.Val1 == 32'd0);
      BR_BNE:  br_cond = (bus.Val1 != bus.Reg2);
      BR_JMP:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  // Stall and redirect: only an idle stage with a single-cycle command may branch
  always_comb begin
    freeze_c = 1'b0;
    taken_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        freeze_c = is_mul;
        taken_c  = !is_mul && br_cond;
      end
      ST_MUL:  freeze_c = 1'b1;
      default: begin
        freeze_c = 1'b0;
        taken_c  = 1'b0;
      end
    endcase
  end

  assign bus.freeze   = freeze_c;
  assign bus.Br_taken = taken_c;
  assign bus.Br_addr  = branch_target(bus.PC_in, bus.Val2);

  // Controller, shift-add multiplier and EX/MEM register; operands are not re-read once MUL starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mcand   <= 32'd0;
      mplier  <= 32'd0;
      acc     <= 32'd0;
      cnt     <= 5'd0;
      exmem_q <= EXMEM_BUBBLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mul) begin
            mcand   <= bus.Val1;
            mplier  <= bus.Val2;
            acc     <= 32'd0;
            cnt     <= 5'd0;
            exmem_q <= EXMEM_BUBBLE;
            state   <= ST_MUL;
          end else begin
            exmem_q <= pass_through;
          end
        end
        ST_MUL: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          exmem_q <= EXMEM_BUBBLE;
          if (cnt == MUL_LAST_ITER) begin
            cnt   <= 5'd0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_DONE: begin
          exmem_q            <= pass_through;
          exmem_q.alu_result <= acc;
          state              <= ST_IDLE;
        end
        default: begin
          exmem_q <= EXMEM_BUBBLE;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ALU_result   = exmem_q.alu_result;
  assign bus.ST_val       = exmem_q.st_val;
  assign bus.Dest_out     = exmem_q.dest;
  assign bus.MEM_R_EN_out = exmem_q.mem_r_en;
  assign bus.MEM_W_EN_out = exmem_q.mem_w_en;
  assign bus.WB_EN_out    = exmem_q.wb_en;

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb/tb_exe_stage_mc.sv - scoreboard bench for exe_stage_mc with a behavioural reference model
module tb_exe_stage_mc;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] r2;
    logic [31:0] pc;
    logic [1:0]  bt;
    logic [4:0]  dest;
    logic        mr;
    logic        mw;
    logic        wb;
  } ins_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  dest;
    logic        mr;
    logic        mw;
    logic        wb;
  } ex_t;

  typedef struct packed {
    logic        fr;
    logic        tk;
    logic [31:0] addr;
  } comb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  ex_t   ex_q[$];
  comb_t comb_q[$];
  ex_t   mon_e;
  comb_t mon_c;

  exe_stage_mc_if bus_if ();

  exe_stage_mc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference arithmetic straight from the command table
  function automatic logic [31:0] ref_result(input ins_t in);
    int unsigned sh;
    logic [63:0] prod;
    sh = in.v2 % 32;
    case (in.cmd)
      4'd0:  return in.v1 + in.v2;
      4'd1:  begin prod = 64'(in.v1) * 64'(in.v2); return prod[31:0]; end
      4'd2:  return in.v1 - in.v2;
      4'd4:  return in.v1 & in.v2;
      4'd5:  return in.v1 | in.v2;
      4'd6:  return ~(in.v1 | in.v2);
      4'd7:  return in.v1 ^ in.v2;
      4'd8:  return in.v1 << sh;
      4'd9:  return $unsigned($signed(in.v1) >>> sh);
      4'd10: return in.v1 >> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input ins_t in);
    if (in.cmd == 4'd1) return 1'b0;
    case (in.bt)
      2'd1:    return in.v1 == 32'd0;
      2'd2:    return in.v1 != in.r2;
      2'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_addr(input ins_t in);
    return in.pc + in.v2 * 32'd4;
  endfunction

  task automatic drive(input ins_t in);
    bus_if.EXE_CMD  = in.cmd;
    bus_if.Val1     = in.v1;
    bus_if.Val2     = in.v2;
    bus_if.Reg2     = in.r2;
    bus_if.PC_in    = in.pc;
    bus_if.Br_type  = in.bt;
    bus_if.Dest     = in.dest;
    bus_if.MEM_R_EN = in.mr;
    bus_if.MEM_W_EN = in.mw;
    bus_if.WB_EN    = in.wb;
  endtask

  // Called 1 time unit after a rising edge; holds the instruction for as long as the stage needs it
  task automatic run_instr(input ins_t in);
    ex_t done_e;
    drive(in);
    done_e = '{res: ref_result(in), st: in.r2, dest: in.dest, mr: in.mr, mw: in.mw, wb: in.wb};
    if (in.cmd == 4'd1) begin
      for (int k = 0; k < 33; k++) begin
        comb_q.push_back('{fr: 1'b1, tk: 1'b0, addr: ref_addr(in)});
        @(posedge clk);
        ex_q.push_back('0);
        #1;
      end
    end
    comb_q.push_back('{fr: 1'b0, tk: ref_taken(in), addr: ref_addr(in)});
    @(posedge clk);
    ex_q.push_back(done_e);
    #1;
  endtask

  function automatic ins_t mk(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] r2, input logic [31:0] pc, input logic [1:0] bt,
                              input logic [4:0] dest, input logic mr, input logic mw, input logic wb);
    return '{cmd: cmd, v1: v1, v2: v2, r2: r2, pc: pc, bt: bt, dest: dest, mr: mr, mw: mw, wb: wb};
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 40);
      1:       return 32'hFFFF_FFFF - $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_alu_result"}, bus_if.ALU_result, 32'd0);
    chk({tag, "_st_val"}, bus_if.ST_val, 32'd0);
    chk({tag, "_dest"}, {27'd0, bus_if.Dest_out}, 32'd0);
    chk({tag, "_enables"}, {29'd0, bus_if.MEM_R_EN_out, bus_if.MEM_W_EN_out, bus_if.WB_EN_out}, 32'd0);
  endtask

  // Monitor: every falling edge compares the EX/MEM register and the combinational outputs
  always @(negedge clk) begin
    if (ex_q.size() > 0) begin
      mon_e = ex_q.pop_front();
      chk("alu_result", bus_if.ALU_result, mon_e.res);
      chk("st_val", bus_if.ST_val, mon_e.st);
      chk("dest_out", {27'd0, bus_if.Dest_out}, {27'd0, mon_e.dest});
      chk("enables", {29'd0, bus_if.MEM_R_EN_out, bus_if.MEM_W_EN_out, bus_if.WB_EN_out},
          {29'd0, mon_e.mr, mon_e.mw, mon_e.wb});
    end
    if (comb_q.size() > 0) begin
      mon_c = comb_q.pop_front();
      chk("freeze", {31'd0, bus_if.freeze}, {31'd0, mon_c.fr});
      chk("br_taken", {31'd0, bus_if.Br_taken}, {31'd0, mon_c.tk});
      chk("br_addr", bus_if.Br_addr, mon_c.addr);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    ins_t in;
    ins_t mul_in;

    // Reset state
    drive(mk(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    #1 rst = 1'b1;
    #1;
    chk_regs_zero("reset");
    chk("reset_freeze", {31'd0, bus_if.freeze}, 32'd0);
    chk("reset_br_taken", {31'd0, bus_if.Br_taken}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases
    run_instr(mk(4'd0, 32'd5, 32'd7, 32'd0, 32'h40, 2'd0, 5'd3, 1'b0, 1'b0, 1'b1));
    run_instr(mk(4'd2, 32'd3, 32'd5, 32'h11, 32'h44, 2'd0, 5'd4, 1'b0, 1'b0, 1'b1));
    run_instr(mk(4'd9, 32'h8000_0000, 32'd4, 32'h22, 32'h48, 2'd0, 5'd5, 1'b0, 1'b0, 1'b1));
    run_instr(mk(4'd1, 32'hFFFF_FFFF, 32'd3, 32'h33, 32'h4C, 2'd3, 5'd9, 1'b0, 1'b0, 1'b1));
    run_instr(mk(4'd0, 32'd1, 32'd4, 32'd2, 32'h100, 2'd2, 5'd0, 1'b0, 1'b0, 1'b0));
    run_instr(mk(4'd0, 32'd2, 32'd4, 32'd2, 32'h100, 2'd2, 5'd0, 1'b0, 1'b0, 1'b0));
    run_instr(mk(4'd3, 32'd9, 32'd9, 32'hABCD, 32'hFFFF_FFF0, 2'd1, 5'd7, 1'b1, 1'b0, 1'b1));
    run_instr(mk(4'd0, 32'd0, 32'h4000_0001, 32'd6, 32'hFFFF_FFFC, 2'd1, 5'd8, 1'b0, 1'b1, 1'b0));

    // Reset during the 10th multiply cycle abandons the product
    mul_in = mk(4'd1, 32'd1234, 32'd5678, 32'h55, 32'h200, 2'd0, 5'd12, 1'b0, 1'b0, 1'b1);
    drive(mul_in);
    for (int k = 0; k < 10; k++) begin
      comb_q.push_back('{fr: 1'b1, tk: 1'b0, addr: ref_addr(mul_in)});
      @(posedge clk);
      ex_q.push_back('0);
      #1;
    end
    #1 rst = 1'b1;
    ex_q.delete();
    comb_q.delete();
    #1;
    chk_regs_zero("midmul_reset");
    chk("midmul_reset_idle_decode_freeze", {31'd0, bus_if.freeze}, 32'd1);
    in = mk(4'd0, 32'd1, 32'd1, 32'd0, 32'h300, 2'd0, 5'd6, 1'b0, 1'b0, 1'b1);
    drive(in);
    #1;
    chk("midmul_reset_freeze_after_add", {31'd0, bus_if.freeze}, 32'd0);
    @(posedge clk);
    #1;
    chk_regs_zero("held_reset");
    rst = 1'b0;
    run_instr(in);
    run_instr(mk(4'd7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd1, 32'h304, 2'd0, 5'd2, 1'b0, 1'b0, 1'b1));

    // Randomised traffic
    for (int n = 0; n < 150; n++) begin
      in.cmd  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) in.cmd = 4'd1;
      in.v1   = rnd_word();
      in.v2   = rnd_word();
      in.r2   = ($urandom_range(0, 3) == 0) ? in.v1 : rnd_word();
      in.pc   = $urandom;
      in.bt   = 2'($urandom_range(0, 3));
      in.dest = 5'($urandom_range(0, 31));
      in.mr   = 1'($urandom_range(0, 1));
      in.mw   = 1'($urandom_range(0, 1));
      in.wb   = 1'($urandom_range(0, 1));
      run_instr(in);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", ex_q.size() + comb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/exe_stage_mc.md
EXE_STAGE_MC -- requirements
Module: exe_stage_mc

Interface
REQ-001 Clock and reset SHALL be: clk  in  1  rising-edge clock for all state; rst  in  1  asynchronous, active-high reset.
REQ-002 Inputs from the ID/EX register SHALL be: EXE_CMD  in  4  operation code; Val1  in  32  operand A; Val2  in  32  operand B / branch offset; Reg2  in  32  store data / BNE compare value; PC_in  in  32  instruction PC+4; Br_type  in  2  branch kind; Dest  in  5  writeback register; MEM_R_EN, MEM_W_EN, WB_EN  in  1 each  control bits.
REQ-003 The EX/MEM outputs SHALL all be registered: ALU_result  out  32; ST_val  out  32; Dest_out  out  5; MEM_R_EN_out, MEM_W_EN_out, WB_EN_out  out  1 each.
REQ-004 The combinational outputs SHALL be: freeze  out  1  holds PC, IF/ID and ID/EX while high; Br_taken  out  1  redirects fetch and flushes upstream; Br_addr  out  32  branch target.

Function
REQ-005 EXE_CMD codes SHALL be: 0000 ADD, 0001 MUL, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR, 1000 SLL, 1001 SRA, 1010 SRL.
REQ-006 Any other EXE_CMD SHALL produce ALU_result 0.
REQ-007 Shift ops SHALL shift Val1 by Val2[4:0].
REQ-008 All arithmetic SHALL be 32-bit two's-complement, with carry and overflow discarded.
REQ-009 MUL SHALL return the low 32 bits of Val1*Val2.
REQ-010 The FSM SHALL have exactly three states: IDLE, MUL, DONE.
REQ-011 In IDLE with a non-MUL command: freeze=0, and on the next edge the EX/MEM registers SHALL capture the ALU result, Reg2, Dest and the control bits, giving 1-cycle latency.
REQ-012 In IDLE with EXE_CMD=MUL: freeze=1, the operands SHALL be latched into the multiplicand/multiplier registers, the accumulator and a 5-bit counter SHALL clear, and the next state SHALL be MUL.
REQ-013 In MUL: freeze=1, one shift-add iteration SHALL occur per cycle, and the counter SHALL increment.
REQ-014 When the counter reaches 31 in MUL, the counter SHALL wrap to 0 and the FSM SHALL go to DONE, so MUL occupies exactly 32 cycles.
REQ-015 In DONE: freeze=0, and on the next edge the EX/MEM registers SHALL capture the accumulator plus the held Dest, Reg2 and control bits, and the FSM SHALL go to IDLE.
REQ-016 In IDLE-with-MUL and in every MUL cycle, the EX/MEM registers SHALL load a bubble: all-zero data, Dest 0, all enables 0.
REQ-017 An instruction issued at cycle T SHALL cause freeze to be high in cycles T..T+32, low in cycle T+33, and the product SHALL be visible on the EX/MEM outputs after the edge that ends T+33.
REQ-018 Br_type codes SHALL be: 00 none, 01 BEZ (taken if Val1==0), 10 BNE (taken if Val1!=Reg2), 11 JMP (always taken).
REQ-019 Br_taken SHALL be asserted only in IDLE with a non-MUL command, and SHALL be 0 in MUL and DONE.
REQ-020 Br_addr SHALL be PC_in + (Val2 << 2), computed modulo 2^32 with wrap-around permitted.
REQ-021 A taken branch SHALL still register its own EX/MEM entry unchanged, with WB_EN and MEM enables passed through as given.
REQ-022 Upstream SHALL hold the ID/EX outputs stable while freeze=1; the block SHALL NOT re-sample the operands after entering MUL.

Reset
REQ-023 rst SHALL act immediately, independent of clk, including mid-MUL.
REQ-024 On reset: state=IDLE; counter, accumulator and operand registers =0; ALU_result, ST_val, Dest_out =0; MEM_R_EN_out, MEM_W_EN_out, WB_EN_out =0.
REQ-025 On reset, freeze and Br_taken SHALL be 0 unless the IDLE decode of the current inputs asserts them.
REQ-026 A multiply interrupted by reset SHALL be abandoned with no partial result emitted.

Structure
REQ-027 The EXE_CMD codes, Br_type codes and FSM state encodings SHALL live in the shared MIPS package/header alongside the ID-stage decode constants.
REQ-028 The single-cycle ALU SHALL be a combinational sub-module named alu, taking EXE_CMD, Val1 and Val2 and returning a result.
REQ-029 The FSM, the multiplier datapath and the EX/MEM registers SHALL remain in exe_stage_mc.

Verification
REQ-030 ADD Val1=5, Val2=7, WB_EN=1, Dest=3 -> after 1 edge ALU_result=12, Dest_out=3, WB_EN_out=1, freeze never high.
REQ-031 SUB Val1=3, Val2=5 -> ALU_result=0xFFFFFFFE; SRA Val1=0x80000000, Val2=4 -> 0xF8000000.
REQ-032 MUL Val1=0xFFFFFFFF, Val2=3, Dest=9 held stable -> freeze high 33 cycles, 33 bubble/no-update cycles on EX/MEM, then ALU_result=0xFFFFFFFD, Dest_out=9.
REQ-033 BNE Val1=1, Reg2=2, PC_in=0x100, Val2=4 -> Br_taken=1, Br_addr=0x110; same stimulus with Val1=2 -> Br_taken=0.
REQ-034 Assert rst in the 10th MUL cycle -> all outputs 0 and state IDLE at once; after release, ADD 1+1 -> ALU_result=2 after 1 edge, with no stale product emitted.
REQ-035 JMP issued while the FSM is in MUL (inputs held as MUL) -> Br_taken stays 0 until DONE has passed.
